// File: rtl/par2ser_tx.sv
// Parallel-to-serial transmitter with a one-word holding register.
// Words leave MSB first, lsb_out flags bit 0, then GAP_CYCLES idle cycles follow.
module par2ser_tx #(
    parameter int WORD_SIZE  = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 serial_out,
    output logic                 lsb_out,
    output logic                 busy
);
    localparam int BIT_W = $clog2(WORD_SIZE);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(WORD_SIZE - 1);
    localparam logic [GAP_W-1:0] GAP_TOP = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t                 state_q, state_d;
    logic                   hold_full_q, hold_full_d;
    logic [WORD_SIZE-1:0]   hold_q, hold_d;
    logic [WORD_SIZE-1:0]   shift_q, shift_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic                   serial_q, serial_d;
    logic                   lsb_q, lsb_d;
    logic [BIT_W-1:0]       next_bit;
    logic                   load;

    always_comb begin
        state_d     = state_q;
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        serial_d    = 1'b0;
        lsb_d       = 1'b0;
        load        = 1'b0;
        next_bit    = bit_cnt_q - BIT_W'(1);

        case (state_q)
            IDLE: load = 1'b1;
            SHIFT: begin
                if (bit_cnt_q != '0) begin
                    bit_cnt_d = next_bit;
                    serial_d  = shift_q[next_bit];
                    lsb_d     = (next_bit == '0);
                end else if (GAP_CYCLES > 0) begin
                    state_d   = GAP;
                    gap_cnt_d = GAP_TOP;
                end else begin
                    load = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    load = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // The held word moves to the shifter as soon as the line is free,
        // so back-to-back words need no idle cycle when GAP_CYCLES is 0.
        if (load) begin
            if (hold_full_q) begin
                shift_d     = hold_q;
                hold_full_d = 1'b0;
                serial_d    = hold_q[WORD_SIZE-1];
                bit_cnt_d   = BIT_TOP;
                state_d     = SHIFT;
            end else begin
                state_d = IDLE;
            end
        end

        if (data_valid && !hold_full_q) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_full_q <= 1'b0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            serial_q    <= 1'b0;
            lsb_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            serial_q    <= serial_d;
            lsb_q       <= lsb_d;
        end
    end

    // Word storage carries no reset; its contents are qualified by hold_full_q and state_q.
    always_ff @(posedge clk) begin
        hold_q  <= hold_d;
        shift_q <= shift_d;
    end

    assign data_ready = ~hold_full_q;
    assign serial_out = serial_q;
    assign lsb_out    = lsb_q;
    assign busy       = (state_q != IDLE) || hold_full_q;
endmodule

// File: tb/tb_par2ser_tx.sv
// Bench for par2ser_tx: a GAP_CYCLES=2 and a GAP_CYCLES=0 instance checked
// every cycle against a word/slot model, a loopback deserializer and literal timing pins.
module tb_par2ser_tx;
    localparam int W  = 8;
    localparam int TR = 2048;
    localparam int BUF = 64;

    logic         clk;
    logic         reset;
    logic [W-1:0] din [2];
    logic         dv  [2];
    logic         rdy [2];
    logic         ser [2];
    logic         lsb [2];
    logic         bsy [2];
    int           cyc = 0;

    par2ser_tx #(.WORD_SIZE(W), .GAP_CYCLES(2)) u_dut_gap2 (
        .clk(clk), .reset(reset), .data_in(din[0]), .data_valid(dv[0]),
        .data_ready(rdy[0]), .serial_out(ser[0]), .lsb_out(lsb[0]), .busy(bsy[0])
    );

    par2ser_tx #(.WORD_SIZE(W), .GAP_CYCLES(0)) u_dut_gap0 (
        .clk(clk), .reset(reset), .data_in(din[1]), .data_valid(dv[1]),
        .data_ready(rdy[1]), .serial_out(ser[1]), .lsb_out(lsb[1]), .busy(bsy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    // Source queues, expected loopback words, and event logs per instance.
    logic [W-1:0] src  [2][BUF];
    int           src_rd [2];
    int           src_wr [2];
    logic [W-1:0] sent [2][BUF];
    int           sent_rd [2];
    int           sent_wr [2];
    int           acc_e [2][BUF];
    int           acc_n [2];
    int           lsb_e [2][BUF];
    int           lsb_n [2];
    logic         tr_ser  [2][TR];
    logic         tr_lsb  [2][TR];
    logic         tr_busy [2][TR];
    bit           s_acc [2];

    // Model: each word occupies W bit slots then GAP zero slots; one word may wait.
    logic [W-1:0] m_word [2];
    logic [W-1:0] m_hold [2];
    bit           m_hf   [2];
    bit           m_act  [2];
    int           m_idx  [2];
    logic         m_ser  [2];
    logic         m_lsb  [2];
    logic         m_busy [2];

    function automatic int gap_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, expected %0h (cycle %0d)", nm, d, act, exp, cyc);
        end
    endtask

    task automatic model_step(input int d, input logic v, input logic [W-1:0] di, input logic rs);
        bit acc;
        int len;
        len = W + gap_of(d);
        if (rs) begin
            m_hf[d] = 0; m_act[d] = 0; m_idx[d] = 0;
            m_ser[d] = 1'b0; m_lsb[d] = 1'b0; m_busy[d] = 1'b0;
        end else begin
            acc = v && !m_hf[d];
            if (!(m_act[d] && m_idx[d] < len)) begin
                if (m_hf[d]) begin
                    m_word[d] = m_hold[d];
                    m_idx[d]  = 0;
                    m_act[d]  = 1;
                    m_hf[d]   = 0;
                end else begin
                    m_act[d] = 0;
                end
            end
            m_ser[d] = 1'b0;
            m_lsb[d] = 1'b0;
            if (m_act[d]) begin
                if (m_idx[d] < W) begin
                    m_ser[d] = m_word[d][W-1-m_idx[d]];
                    m_lsb[d] = (m_idx[d] == W-1);
                end
                m_idx[d]++;
            end
            if (acc) begin
                m_hold[d] = di;
                m_hf[d]   = 1;
            end
            m_busy[d] = m_act[d] || m_hf[d];
        end
    endtask

    // Per-cycle compare process with loopback deserializer.
    initial begin : compare
        logic         c_v [2];
        logic [W-1:0] c_d [2];
        logic         c_rst;
        logic [W-1:0] sr [2];
        logic [W-1:0] word;
        sr[0] = '0; sr[1] = '0;
        forever begin
            @(posedge clk);
            c_rst = reset;
            for (int d = 0; d < 2; d++) begin
                c_v[d] = dv[d];
                c_d[d] = din[d];
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                model_step(d, c_v[d], c_d[d], c_rst);
                chk("serial_out", d, 32'(ser[d]), 32'(m_ser[d]));
                chk("lsb_out",    d, 32'(lsb[d]), 32'(m_lsb[d]));
                chk("busy",       d, 32'(bsy[d]), 32'(m_busy[d]));
                chk("data_ready", d, 32'(rdy[d]), 32'(!m_hf[d]));
                if (cyc < TR) begin
                    tr_ser[d][cyc]  = ser[d];
                    tr_lsb[d][cyc]  = lsb[d];
                    tr_busy[d][cyc] = bsy[d];
                end
                if (lsb[d] === 1'b1) begin
                    word = {sr[d][W-2:0], ser[d]};
                    if (lsb_n[d] < BUF) lsb_e[d][lsb_n[d]] = cyc;
                    lsb_n[d]++;
                    if (sent_rd[d] != sent_wr[d]) begin
                        chk("loopback_word", d, 32'(word), 32'(sent[d][sent_rd[d] % BUF]));
                        sent_rd[d]++;
                    end else begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_word dut%0d: got %0h, expected no word (cycle %0d)", d, word, cyc);
                    end
                end
                sr[d] = {sr[d][W-2:0], ser[d]};
            end
        end
    end

    // Sources: present queued words and hold each until the instance accepts it.
    initial begin : source
        dv[0] = 1'b0; dv[1] = 1'b0; din[0] = '0; din[1] = '0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) s_acc[d] = dv[d] && rdy[d];
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (s_acc[d] && !reset && src_rd[d] != src_wr[d]) begin
                    if (acc_n[d] < BUF) acc_e[d][acc_n[d]] = cyc;
                    acc_n[d]++;
                    src_rd[d]++;
                end
                if (src_rd[d] != src_wr[d]) begin
                    dv[d]  = 1'b1;
                    din[d] = src[d][src_rd[d] % BUF];
                end else begin
                    dv[d] = 1'b0;
                end
            end
        end
    end

    task automatic start_test();
        @(negedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            acc_n[d] = 0;
            lsb_n[d] = 0;
        end
    endtask

    task automatic push(input logic [W-1:0] w);
        for (int d = 0; d < 2; d++) begin
            src[d][src_wr[d] % BUF]   = w;
            src_wr[d]++;
            sent[d][sent_wr[d] % BUF] = w;
            sent_wr[d]++;
        end
    endtask

    task automatic wait_idle(input string nm);
        bit done;
        done = 0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            #3;
            if (src_rd[0] == src_wr[0] && src_rd[1] == src_wr[1] && bsy[0] === 1'b0 && bsy[1] === 1'b0)
                done = 1;
        end
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_timeout: got busy after 600 cycles, expected idle", nm);
        end
        for (int d = 0; d < 2; d++) chk({nm, "_drained"}, d, 32'(sent_rd[d]), 32'(sent_wr[d]));
    endtask

    task automatic wait_acc(input int d, input int n);
        for (int i = 0; i < 100 && acc_n[d] < n; i++) begin
            @(negedge clk);
            #3;
        end
        n_chk++;
        if (acc_n[d] < n) begin
            n_fail++;
            $display("FAIL accept_timeout dut%0d: got %0d accepts, expected %0d", d, acc_n[d], n);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic exp_ser [8];
        logic exp_lsb [8];
        int k, e0;
        for (int d = 0; d < 2; d++) begin
            src_rd[d] = 0; src_wr[d] = 0; sent_rd[d] = 0; sent_wr[d] = 0;
            acc_n[d] = 0; lsb_n[d] = 0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_serial", d, 32'(ser[d]), 0);
            chk("reset_lsb",    d, 32'(lsb[d]), 0);
            chk("reset_busy",   d, 32'(bsy[d]), 0);
            chk("reset_ready",  d, 32'(rdy[d]), 1);
        end
        #2 reset = 1'b0;

        // Single word 0xA5.
        start_test();
        push(8'hA5);
        wait_idle("t1");
        exp_ser = '{1, 0, 1, 0, 0, 1, 0, 1};
        exp_lsb = '{0, 0, 0, 0, 0, 0, 0, 1};
        k = acc_e[0][0];
        for (int i = 1; i <= 8; i++) begin
            chk("t1_serial", 0, 32'(tr_ser[0][k+i]), 32'(exp_ser[i-1]));
            chk("t1_lsb",    0, 32'(tr_lsb[0][k+i]), 32'(exp_lsb[i-1]));
        end
        chk("t1_gap9",   0, 32'(tr_ser[0][k+9]),   0);
        chk("t1_gap10",  0, 32'(tr_ser[0][k+10]),  0);
        chk("t1_busy10", 0, 32'(tr_busy[0][k+10]), 1);
        chk("t1_busy11", 0, 32'(tr_busy[0][k+11]), 0);
        k = acc_e[1][0];
        chk("t1_busy8",  1, 32'(tr_busy[1][k+8]), 1);
        chk("t1_busy9",  1, 32'(tr_busy[1][k+9]), 0);

        // Back-to-back 0x13, 0x26.
        start_test();
        push(8'h13);
        push(8'h26);
        wait_idle("t2");
        chk("t2_accept_gap", 0, 32'(acc_e[0][1] - acc_e[0][0]), 2);
        chk("t2_accept_gap", 1, 32'(acc_e[1][1] - acc_e[1][0]), 2);
        chk("t2_word_spacing", 0, 32'(lsb_e[0][1] - lsb_e[0][0]), 10);
        chk("t2_word_spacing", 1, 32'(lsb_e[1][1] - lsb_e[1][0]), 8);

        // Backpressure with three queued words.
        start_test();
        push(8'h01);
        push(8'h80);
        push(8'hFF);
        wait_idle("t3");
        chk("t3_words", 0, 32'(lsb_n[0]), 3);
        chk("t3_accept12", 0, 32'(acc_e[0][1] - acc_e[0][0]), 2);
        chk("t3_accept23", 0, 32'(acc_e[0][2] - acc_e[0][1]), 10);
        chk("t3_accept23", 1, 32'(acc_e[1][2] - acc_e[1][1]), 8);

        // Loopback sweep 0,19,...,247.
        start_test();
        for (int i = 0; i < 14; i++) push(W'(i * 19));
        wait_idle("t4");
        chk("t4_words", 0, 32'(lsb_n[0]), 14);
        chk("t4_words", 1, 32'(lsb_n[1]), 14);

        // Reset during bit 4 of 0xF0 while 0x0F is held.
        start_test();
        push(8'hF0);
        push(8'h0F);
        wait_acc(0, 1);
        k = acc_e[0][0];
        for (int i = 0; i < 20 && cyc < k + 4; i++) @(negedge clk);
        chk("t5_bit4", 0, 32'(ser[0]), 1);
        chk("t5_held", 0, 32'(acc_n[0]), 2);
        #2 reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            src_rd[d]  = src_wr[d];
            sent_rd[d] = sent_wr[d];
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("t5_serial", d, 32'(ser[d]), 0);
            chk("t5_lsb",    d, 32'(lsb[d]), 0);
            chk("t5_busy",   d, 32'(bsy[d]), 0);
            chk("t5_ready",  d, 32'(rdy[d]), 1);
        end
        #2 reset = 1'b0;
        repeat (30) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("t5_no_resume", d, 32'(lsb_n[d]), 0);
            chk("t5_idle",      d, 32'(bsy[d]),   0);
        end

        // 0xC3 then 0x3C: back-to-back with no gap on the GAP_CYCLES=0 instance.
        start_test();
        push(8'hC3);
        push(8'h3C);
        wait_idle("t6");
        e0 = lsb_e[1][0];
        chk("t6_pulses",   1, 32'(lsb_n[1]), 2);
        chk("t6_spacing",  1, 32'(lsb_e[1][1] - e0), 8);
        chk("t6_c3_lsb",   1, 32'(tr_ser[1][e0]), 1);
        chk("t6_3c_msb",   1, 32'(tr_ser[1][e0+1]), 0);
        chk("t6_no_idle",  1, 32'(tr_busy[1][e0+1]), 1);
        chk("t6_spacing",  0, 32'(lsb_e[0][1] - lsb_e[0][0]), 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
